// File: rtl/tlight_package.sv
// Shared types and lamp encodings for the traffic-light safety monitor.
// Lamp vectors are {red,yellow,green}; an all-zero vector is the dark flash phase.
package tlight_package;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } tlight_control_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_CONFLICT = 2'd1,
      FAULT_SEQUENCE = 2'd2,
      FAULT_TIMEOUT  = 2'd3
   } tlight_fault_t;

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_MONITOR,
      ST_FAULT
   } tlight_state_t;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_OFF    = 3'b000;

   function automatic logic aspect_valid(input tlight_control_t a);
      return (a == RED) || (a == YELLOW) || (a == GREEN);
   endfunction

   function automatic logic [2:0] lamp_decode(input tlight_control_t a);
      case (a)
         RED:     return LAMP_RED;
         YELLOW:  return LAMP_YELLOW;
         GREEN:   return LAMP_GREEN;
         default: return LAMP_OFF;
      endcase
   endfunction

endpackage

// File: rtl/tlight_aspect_checker.sv
// Per-approach checker: tracks the previous aspect and the non-RED run length,
// flagging illegal transitions/encodings and over-long non-RED runs.
module tlight_aspect_checker
   import tlight_package::*;
#(
   parameter int unsigned MAX_NON_RED = 24
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            update,
   input  tlight_control_t aspect,
   output logic            seq_err,
   output logic            timeout_err
);

   localparam int unsigned CW = $clog2(MAX_NON_RED + 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_NON_RED);
   localparam logic [CW-1:0] CNT_SAT = CW'(MAX_NON_RED + 1);

   tlight_control_t prev;
   logic [CW-1:0]   run_cnt;
   logic [CW-1:0]   run_cnt_next;

   always_comb begin
      run_cnt_next = run_cnt;
      if (aspect == RED)
         run_cnt_next = '0;
      else if (run_cnt < CNT_SAT)
         run_cnt_next = run_cnt + CW'(1);
   end

   always_comb begin
      seq_err = !aspect_valid(aspect)
                || ((prev == GREEN) && (aspect == RED))
                || ((prev == RED) && (aspect == GREEN));
      // the aspect shown this cycle would be run number run_cnt+1
      timeout_err = (aspect != RED) && (run_cnt >= CNT_MAX);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev    <= RED;
         run_cnt <= '0;
      end else if (load) begin
         prev    <= aspect;
         run_cnt <= (aspect == RED) ? '0 : CW'(1);
      end else if (update) begin
         prev    <= aspect;
         run_cnt <= run_cnt_next;
      end
   end

endmodule

// File: rtl/tlight_safety_monitor.sv
// Traffic-light safety monitor: passes controller aspects to the lamps one cycle
// late and forces a latched yellow flash on conflict, sequence or timeout faults.
// Optional fault counter enabled by defining TLIGHT_FAULT_COUNT_EN.
module tlight_safety_monitor
   import tlight_package::*;
#(
   parameter int unsigned MAX_NON_RED = 24,
   parameter int unsigned BLINK_HALF  = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  tlight_control_t ns_in,
   input  tlight_control_t we_in,
   input  logic            fault_clear,
   output logic [2:0]      ns_lamp,
   output logic [2:0]      we_lamp,
   output logic            fault,
`ifdef TLIGHT_FAULT_COUNT_EN
   output logic [7:0]      fault_count,
`endif
   output tlight_fault_t   fault_code
);

   localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   tlight_state_t state;
   tlight_state_t state_next;

   logic          ns_seq, ns_timeout;
   logic          we_seq, we_timeout;
   logic          conflict;
   logic          detected;
   logic          clear_ok;
   tlight_fault_t det_code;

   logic [2:0]    ns_lamp_d;
   logic [2:0]    we_lamp_d;
   tlight_fault_t code_d;
   logic          blink_on;
   logic          blink_on_d;
   logic [BW-1:0] blink_cnt;
   logic [BW-1:0] blink_cnt_d;

   tlight_aspect_checker #(.MAX_NON_RED(MAX_NON_RED)) u_ns_check (
      .clock       (clock),
      .reset       (reset),
      .load        (state == ST_STARTUP),
      .update      (state == ST_MONITOR),
      .aspect      (ns_in),
      .seq_err     (ns_seq),
      .timeout_err (ns_timeout)
   );

   tlight_aspect_checker #(.MAX_NON_RED(MAX_NON_RED)) u_we_check (
      .clock       (clock),
      .reset       (reset),
      .load        (state == ST_STARTUP),
      .update      (state == ST_MONITOR),
      .aspect      (we_in),
      .seq_err     (we_seq),
      .timeout_err (we_timeout)
   );

   always_comb begin
      conflict = (ns_in != RED) && (we_in != RED);
      clear_ok = fault_clear && (ns_in == RED) && (we_in == RED);
      if (conflict)
         det_code = FAULT_CONFLICT;
      else if (ns_seq || we_seq)
         det_code = FAULT_SEQUENCE;
      else if (ns_timeout || we_timeout)
         det_code = FAULT_TIMEOUT;
      else
         det_code = FAULT_NONE;
      detected = (det_code != FAULT_NONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= ST_STARTUP;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_STARTUP: state_next = ST_MONITOR;
         ST_MONITOR: if (detected) state_next = ST_FAULT;
         ST_FAULT:   if (clear_ok) state_next = ST_STARTUP;
         default:    state_next = ST_STARTUP;
      endcase
   end

   always_comb begin
      ns_lamp_d   = LAMP_RED;
      we_lamp_d   = LAMP_RED;
      code_d      = fault_code;
      blink_on_d  = blink_on;
      blink_cnt_d = blink_cnt;
      unique case (state)
         ST_STARTUP: code_d = FAULT_NONE;
         ST_MONITOR: begin
            if (detected) begin
               ns_lamp_d   = LAMP_YELLOW;
               we_lamp_d   = LAMP_YELLOW;
               code_d      = det_code;
               blink_on_d  = 1'b1;
               blink_cnt_d = '0;
            end else begin
               ns_lamp_d = lamp_decode(ns_in);
               we_lamp_d = lamp_decode(we_in);
            end
         end
         ST_FAULT: begin
            if (clear_ok) begin
               code_d      = FAULT_NONE;
               blink_on_d  = 1'b1;
               blink_cnt_d = '0;
            end else begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_on_d  = !blink_on;
                  blink_cnt_d = '0;
               end else begin
                  blink_cnt_d = blink_cnt + BW'(1);
               end
               ns_lamp_d = blink_on_d ? LAMP_YELLOW : LAMP_OFF;
               we_lamp_d = blink_on_d ? LAMP_YELLOW : LAMP_OFF;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ns_lamp    <= LAMP_RED;
         we_lamp    <= LAMP_RED;
         fault_code <= FAULT_NONE;
         blink_on   <= 1'b1;
         blink_cnt  <= '0;
      end else begin
         ns_lamp    <= ns_lamp_d;
         we_lamp    <= we_lamp_d;
         fault_code <= code_d;
         blink_on   <= blink_on_d;
         blink_cnt  <= blink_cnt_d;
      end
   end

   assign fault = (state == ST_FAULT);

`ifdef TLIGHT_FAULT_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         fault_count <= '0;
      else if ((state == ST_MONITOR) && detected && (fault_count != 8'hFF))
         fault_count <= fault_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_tlight_safety_monitor.sv
// Directed self-checking bench for tlight_safety_monitor; checks the
// fault_count output too when TLIGHT_FAULT_COUNT_EN is defined.
module tb_tlight_safety_monitor;
   import tlight_package::*;

   logic            clock;
   logic            reset;
   tlight_control_t ns_in;
   tlight_control_t we_in;
   logic            fault_clear;
   logic [2:0]      ns_lamp;
   logic [2:0]      we_lamp;
   logic            fault;
   tlight_fault_t   fault_code;
`ifdef TLIGHT_FAULT_COUNT_EN
   logic [7:0]      fault_count;
`endif

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   tlight_safety_monitor #(.MAX_NON_RED(24), .BLINK_HALF(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .ns_in       (ns_in),
      .we_in       (we_in),
      .fault_clear (fault_clear),
      .ns_lamp     (ns_lamp),
      .we_lamp     (we_lamp),
      .fault       (fault),
`ifdef TLIGHT_FAULT_COUNT_EN
      .fault_count (fault_count),
`endif
      .fault_code  (fault_code)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   function automatic logic [7:0] lamp_of(input tlight_control_t a);
      case (a)
         RED:     return 8'b100;
         YELLOW:  return 8'b010;
         GREEN:   return 8'b001;
         default: return 8'b000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [7:0] en, input logic [7:0] ew,
                             input logic [7:0] ef, input logic [7:0] ec);
      chk({tag, ".ns_lamp"}, {5'd0, ns_lamp}, en);
      chk({tag, ".we_lamp"}, {5'd0, we_lamp}, ew);
      chk({tag, ".fault"}, {7'd0, fault}, ef);
      chk({tag, ".code"}, {6'd0, fault_code}, ec);
   endtask

   // Apply inputs for one cycle; outputs sampled 1 time unit after the edge.
   task automatic cyc(input tlight_control_t n, input tlight_control_t w, input logic clr);
      ns_in = n;
      we_in = w;
      fault_clear = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic restart(input string tag);
      cyc(RED, RED, 1'b1);
      expect_all({tag, ".clear"}, 8'b100, 8'b100, 8'd0, 8'd0);
      cyc(RED, RED, 1'b0);
      expect_all({tag, ".startup"}, 8'b100, 8'b100, 8'd0, 8'd0);
   endtask

   tlight_control_t asp;
   tlight_control_t bad;

   initial begin
      bad = tlight_control_t'(2'd3);
      reset = 1'b1;
      ns_in = GREEN;
      we_in = GREEN;
      fault_clear = 1'b0;
      #3;
      expect_all("reset", 8'b100, 8'b100, 8'd0, 8'd0);
`ifdef TLIGHT_FAULT_COUNT_EN
      chk("reset.count", fault_count, 8'd0);
`endif
      ns_in = RED;
      we_in = RED;
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc(RED, RED, 1'b0);
      expect_all("startup", 8'b100, 8'b100, 8'd0, 8'd0);

      // Legal cycle: WE Y3/G15/Y1 then NS Y3/G15/Y1, three times.
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 2; a++) begin
            for (int p = 0; p < 19; p++) begin
               asp = (p < 3 || p == 18) ? YELLOW : GREEN;
               if (a == 0) begin
                  cyc(RED, asp, 1'b0);
                  expect_all("legal.we", 8'b100, lamp_of(asp), 8'd0, 8'd0);
               end else begin
                  cyc(asp, RED, 1'b0);
                  expect_all("legal.ns", lamp_of(asp), 8'b100, 8'd0, 8'd0);
               end
            end
         end
      end
      cyc(RED, RED, 1'b0);
      expect_all("legal.end", 8'b100, 8'b100, 8'd0, 8'd0);

      // Conflict, flash pattern and clear handling.
      cyc(YELLOW, RED, 1'b0);
      expect_all("conf.pre1", 8'b010, 8'b100, 8'd0, 8'd0);
      cyc(GREEN, RED, 1'b0);
      expect_all("conf.pre2", 8'b001, 8'b100, 8'd0, 8'd0);
      cyc(GREEN, YELLOW, 1'b0);
      expect_all("conf.detect", 8'b010, 8'b010, 8'd1, 8'd1);
      cyc(RED, RED, 1'b0);
      expect_all("conf.off", 8'b000, 8'b000, 8'd1, 8'd1);
      cyc(RED, RED, 1'b0);
      expect_all("conf.on", 8'b010, 8'b010, 8'd1, 8'd1);
      cyc(GREEN, RED, 1'b1);
      expect_all("conf.badclear", 8'b000, 8'b000, 8'd1, 8'd1);
      restart("conf");
      cyc(RED, YELLOW, 1'b1);
      expect_all("monitor.clrignored", 8'b100, 8'b010, 8'd0, 8'd0);
      cyc(RED, RED, 1'b0);
      expect_all("monitor.red", 8'b100, 8'b100, 8'd0, 8'd0);

      // Sequence faults: GREEN->RED, RED->GREEN, invalid encoding.
      cyc(YELLOW, RED, 1'b0);
      cyc(GREEN, RED, 1'b0);
      expect_all("seq.pre", 8'b001, 8'b100, 8'd0, 8'd0);
      cyc(RED, RED, 1'b0);
      expect_all("seq.g2r", 8'b010, 8'b010, 8'd1, 8'd2);
      restart("seq1");
      cyc(RED, GREEN, 1'b0);
      expect_all("seq.r2g", 8'b010, 8'b010, 8'd1, 8'd2);
      restart("seq2");

      // Timeout: Y then G; the 25th consecutive non-RED cycle trips.
      cyc(RED, YELLOW, 1'b0);
      expect_all("tmo.y", 8'b100, 8'b010, 8'd0, 8'd0);
      for (int k = 0; k < 23; k++) begin
         cyc(RED, GREEN, 1'b0);
         expect_all("tmo.g", 8'b100, 8'b001, 8'd0, 8'd0);
      end
      cyc(RED, GREEN, 1'b0);
      expect_all("tmo.trip", 8'b010, 8'b010, 8'd1, 8'd3);
      restart("tmo");

      // Conflict together with a sequence error records CONFLICT.
      cyc(YELLOW, RED, 1'b0);
      cyc(GREEN, RED, 1'b0);
      cyc(GREEN, GREEN, 1'b0);
      expect_all("simul.detect", 8'b010, 8'b010, 8'd1, 8'd1);
      cyc(RED, RED, 1'b0);
      expect_all("simul.off", 8'b000, 8'b000, 8'd1, 8'd1);

      // Reset in the dark half of the flash takes effect immediately.
      reset = 1'b1;
      #1;
      expect_all("midreset", 8'b100, 8'b100, 8'd0, 8'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc(RED, RED, 1'b0);
      expect_all("postreset", 8'b100, 8'b100, 8'd0, 8'd0);

      for (int f = 0; f < 3; f++) begin
         cyc(RED, bad, 1'b0);
         expect_all("invalid", 8'b010, 8'b010, 8'd1, 8'd2);
         restart("invalid");
      end
`ifdef TLIGHT_FAULT_COUNT_EN
      chk("fault_count", fault_count, 8'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
